// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default width, FSM state
// encoding and the fill bit used to build the divide-by-zero quotient.
package div_pkg;

  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // A zero divisor yields an all-ones quotient; replicate this bit to DATA_W.
  localparam logic DIV_ZERO_BIT = 1'b1;

endpackage

// File: rtl/div_sub_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference if it fits.
module div_sub_step #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic              bit_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  logic [DATA_W:0] diff;

  // Borrow out of the (DATA_W+1)-bit trial subtraction means "does not fit".
  always_comb begin
    diff    = {rem_in, bit_in} - {1'b0, divisor};
    q_bit   = ~diff[DATA_W];
    rem_out = q_bit ? diff[DATA_W-1:0] : {rem_in[DATA_W-2:0], bit_in};
  end

endmodule

// File: rtl/seq_div16_16.sv
// Iterative restoring divider, one quotient bit per clock, MSB first.
// Optional signed (truncate-toward-zero) mode is enabled by defining
// SEQ_DIV_SIGNED_EN; without it in_signed has no effect and ovf stays 0.
module seq_div16_16
  import div_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_zero,
  output logic              ovf
);

`ifdef SEQ_DIV_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  localparam int                CNT_W     = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] acc_reg;       // partial remainder
  logic [DATA_W-1:0] quo_reg;       // dividend bits shifting out, quotient bits in
  logic [DATA_W-1:0] dvs_reg;       // divisor magnitude
  logic [DATA_W-1:0] dvd_orig_reg;  // raw dividend, returned on divide-by-zero
  logic              neg_q_reg;
  logic              neg_r_reg;
  logic              zero_reg;
  logic              ovf_pend_reg;

  logic              signed_req;
  logic              dvd_neg;
  logic              dvs_neg;
  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W-1:0] dvs_mag;
  logic              ovf_in;
  logic [DATA_W-1:0] rem_step;
  logic              q_bit;
  logic [DATA_W-1:0] final_q;

  // Operand conditioning at acceptance: magnitudes, result signs, overflow.
  always_comb begin
    signed_req = in_signed & SIGNED_EN;
    dvd_neg    = signed_req & dividend[DATA_W-1];
    dvs_neg    = signed_req & divisor[DATA_W-1];
    dvd_mag    = dvd_neg ? (~dividend + 1'b1) : dividend;
    dvs_mag    = dvs_neg ? (~divisor + 1'b1) : divisor;
    ovf_in     = signed_req && (dividend == MOST_NEG) && (divisor == '1);
    final_q    = {quo_reg[DATA_W-2:0], q_bit};
  end

  div_sub_step #(.DATA_W(DATA_W)) u_step (
    .rem_in  (acc_reg),
    .bit_in  (quo_reg[DATA_W-1]),
    .divisor (dvs_reg),
    .rem_out (rem_step),
    .q_bit   (q_bit)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      quo_reg      <= '0;
      dvs_reg      <= '0;
      dvd_orig_reg <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      zero_reg     <= 1'b0;
      ovf_pend_reg <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_zero     <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            acc_reg      <= '0;
            quo_reg      <= dvd_mag;
            dvs_reg      <= dvs_mag;
            dvd_orig_reg <= dividend;
            neg_q_reg    <= dvd_neg ^ dvs_neg;
            neg_r_reg    <= dvd_neg;
            zero_reg     <= (divisor == '0);
            ovf_pend_reg <= ovf_in;
            cnt_reg      <= '0;
            in_ready     <= 1'b0;
            state_reg    <= CALC;
          end
        end
        CALC: begin
          if (zero_reg) begin
            // Zero divisor: no iteration, result is ready on the first CALC edge.
            quotient  <= {DATA_W{DIV_ZERO_BIT}};
            remainder <= dvd_orig_reg;
            div_zero  <= 1'b1;
            ovf       <= 1'b0;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            acc_reg <= rem_step;
            quo_reg <= final_q;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_STEP) begin
              quotient  <= neg_q_reg ? (~final_q + 1'b1) : final_q;
              remainder <= neg_r_reg ? (~rem_step + 1'b1) : rem_step;
              div_zero  <= 1'b0;
              ovf       <= ovf_pend_reg;
              out_valid <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
